// File: rtl/fifo_wa_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_wa_pkg
// Purpose  : Shared helpers and legal-ratio checks for fifo_width_adapter.
// Revision : 1.0
// ----------------------------------------------------------------------------
package fifo_wa_pkg;

  localparam int unsigned C_MAX_RATIO = 16;

  function automatic bit ratio_ok(input int unsigned ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4) ||
           (ratio == 8) || (ratio == 16);
  endfunction

  function automatic int unsigned min_avail(input int unsigned cnt,
                                            input int unsigned ratio);
    return (cnt < ratio) ? cnt : ratio;
  endfunction

  // Thermometer mask from bit 0: lanes below avail are valid.
  function automatic logic [C_MAX_RATIO-1:0] keep_mask(input int unsigned avail,
                                                       input int unsigned ratio);
    logic [C_MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < C_MAX_RATIO; i++) begin
      m[i] = (i < avail) && (i < ratio);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wa_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_wa_mem
// Purpose  : DEPTH x IN_WIDTH register array, one write port, RATIO read taps.
// Revision : 1.0
// ----------------------------------------------------------------------------
module fifo_wa_mem #(
  parameter int IN_WIDTH   = 8,
  parameter int RATIO      = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     w_addr,
  input  logic [IN_WIDTH-1:0]       w_data,
  input  logic [ADDR_WIDTH-1:0]     rd_ptr,
  output logic [RATIO*IN_WIDTH-1:0] taps
);

  localparam int C_DEPTH = 2 ** ADDR_WIDTH;

  logic [IN_WIDTH-1:0] mem_q [C_DEPTH];
  logic [IN_WIDTH-1:0] mem_d [C_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[w_addr] = w_data;
  end

  // Contents are intentionally never cleared; pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Tap addresses wrap modulo DEPTH, so a straddling beat reads in one cycle.
  for (genvar i = 0; i < RATIO; i++) begin : g_tap
    assign taps[i*IN_WIDTH +: IN_WIDTH] = mem_q[rd_ptr + ADDR_WIDTH'(i)];
  end

endmodule
`default_nettype wire

// File: rtl/fifo_width_adapter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_width_adapter
// Purpose  : N-to-1 width-up FIFO with drain, flush, watermarks, error pulses.
// Revision : 1.0
// ----------------------------------------------------------------------------
module fifo_width_adapter
  import fifo_wa_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int RATIO      = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - RATIO,
  parameter int AE_LEVEL   = RATIO
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       w_data,
  input  logic                      wr_en,
  output logic                      full,
  output logic                      almost_full,
  output logic [RATIO*IN_WIDTH-1:0] r_data,
  output logic [RATIO-1:0]          r_keep,
  input  logic                      rd_en,
  input  logic                      drain,
  output logic                      empty,
  output logic                      almost_empty,
  input  logic                      flush,
  output logic [ADDR_WIDTH:0]       count,
  output logic                      wr_err,
  output logic                      rd_err
);

  localparam int C_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH_W = (ADDR_WIDTH+1)'(C_DEPTH);
  localparam logic [ADDR_WIDTH:0] C_RATIO_W = (ADDR_WIDTH+1)'(RATIO);
  localparam logic [ADDR_WIDTH:0] C_AF_W    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AE_W    = (ADDR_WIDTH+1)'(AE_LEVEL);

  if (!ratio_ok(RATIO) || (C_DEPTH < 2 * RATIO)) begin : g_cfg_err
    $error("fifo_width_adapter: RATIO must be a power of two 1..16 and DEPTH >= 2*RATIO");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;

  logic                      wr_fire, rd_fire;
  logic [ADDR_WIDTH:0]       avail, rd_words;
  logic [RATIO*IN_WIDTH-1:0] taps;

  assign full         = (count_q == C_DEPTH_W);
  assign almost_full  = (count_q >= C_AF_W);
  assign empty        = drain ? (count_q == '0) : (count_q < C_RATIO_W);
  assign almost_empty = (count_q <= C_AE_W);
  assign count        = count_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

  assign wr_fire  = wr_en & ~full;
  assign rd_fire  = rd_en & ~empty;
  assign avail    = (ADDR_WIDTH+1)'(min_avail(32'(count_q), RATIO));
  assign rd_words = rd_fire ? avail : '0;

  fifo_wa_mem #(
    .IN_WIDTH  (IN_WIDTH),
    .RATIO     (RATIO),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire & ~flush & ~rst),
    .w_addr(wr_ptr_q),
    .w_data(w_data),
    .rd_ptr(rd_ptr_q),
    .taps  (taps)
  );

  // Lanes beyond the available word count read as zero.
  always_comb begin
    r_keep = RATIO'(keep_mask(32'(avail), RATIO));
    r_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_keep[i]) r_data[i*IN_WIDTH +: IN_WIDTH] = taps[i*IN_WIDTH +: IN_WIDTH];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_fire);
    rd_ptr_d = rd_ptr_q + rd_words[ADDR_WIDTH-1:0];
    count_d  = count_q + {{ADDR_WIDTH{1'b0}}, wr_fire} - rd_words;
    wr_err_d = wr_en & full;
    rd_err_d = rd_en & empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wr_err_d = 1'b0;
      rd_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_width_adapter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_fifo_width_adapter
// Purpose  : Directed self-checking bench for fifo_width_adapter (8b x4, depth 16).
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_fifo_width_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  w_data = '0;
  logic        wr_en = 1'b0;
  logic        full, almost_full;
  logic [31:0] r_data;
  logic [3:0]  r_keep;
  logic        rd_en = 1'b0;
  logic        drain = 1'b0;
  logic        empty, almost_empty;
  logic        flush = 1'b0;
  logic [4:0]  count;
  logic        wr_err, rd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_width_adapter #(.IN_WIDTH(8), .RATIO(4), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .w_data(w_data), .wr_en(wr_en), .full(full),
    .almost_full(almost_full), .r_data(r_data), .r_keep(r_keep), .rd_en(rd_en),
    .drain(drain), .empty(empty), .almost_empty(almost_empty), .flush(flush),
    .count(count), .wr_err(wr_err), .rd_err(rd_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    w_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_beat();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({full, almost_full, empty, almost_empty} !== 4'b0011) begin errors++; $display("FAIL reset_flags got %b exp 0011", {full, almost_full, empty, almost_empty}); end
    checks++; if ({r_keep, r_data} !== 36'd0) begin errors++; $display("FAIL reset_data got keep %h data %h exp 0", r_keep, r_data); end
    checks++; if ({wr_err, rd_err} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {wr_err, rd_err}); end
  endtask

  task automatic test_fill_read();
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    checks++; if (count !== 5'd4 || empty !== 1'b0) begin errors++; $display("FAIL fill_count got %0d empty %b exp 4 0", count, empty); end
    checks++; if (r_data !== 32'h44332211 || r_keep !== 4'hF) begin errors++; $display("FAIL fill_data got %h keep %h exp 44332211 f", r_data, r_keep); end
    read_beat();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || r_keep !== 4'h0) begin errors++; $display("FAIL fill_after_read got cnt %0d empty %b keep %h exp 0 1 0", count, empty, r_keep); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      write_word(8'h80 + 8'(i));
      if (i == 10) begin
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_at_11 got %b exp 0", almost_full); end
      end
      if (i == 11) begin
        checks++; if (almost_full !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL af_at_12 got af %b full %b exp 1 0", almost_full, full); end
      end
    end
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL full_16 got full %b cnt %0d exp 1 16", full, count); end
    write_word(8'hFF);
    checks++; if (wr_err !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL wr_err_pulse got err %b cnt %0d exp 1 16", wr_err, count); end
    step();
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_clear got %b exp 0", wr_err); end
    checks++; if (r_data !== 32'h83828180) begin errors++; $display("FAIL full_beat0 got %h exp 83828180", r_data); end
    read_beat(); read_beat(); read_beat();
    checks++; if (r_data !== 32'h8f8e8d8c) begin errors++; $display("FAIL full_beat3 got %h exp 8f8e8d8c", r_data); end
    read_beat();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    do_flush();
    for (int i = 0; i < 14; i++) write_word(8'h20 + 8'(i));
    read_beat(); read_beat(); read_beat();
    checks++; if (count !== 5'd2 || r_data !== 32'h00002d2c || r_keep !== 4'b0011) begin errors++; $display("FAIL wrap_partial got cnt %0d data %h keep %b exp 2 00002d2c 0011", count, r_data, r_keep); end
    for (int i = 0; i < 6; i++) write_word(8'h2E + 8'(i));
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL wrap_count got %0d exp 8", count); end
    checks++; if (r_data !== 32'h2f2e2d2c) begin errors++; $display("FAIL wrap_straddle got %h exp 2f2e2d2c", r_data); end
    read_beat();
    checks++; if (r_data !== 32'h33323130 || count !== 5'd4) begin errors++; $display("FAIL wrap_next got %h cnt %0d exp 33323130 4", r_data, count); end
    read_beat();
  endtask

  task automatic test_back_to_back();
    do_flush();
    for (int i = 0; i < 5; i++) write_word(8'h50 + 8'(i));
    w_data = 8'h55; wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd2 || empty !== 1'b1) begin errors++; $display("FAIL simul_count got cnt %0d empty %b exp 2 1", count, empty); end
    checks++; if (r_data !== 32'h00005554 || r_keep !== 4'b0011) begin errors++; $display("FAIL simul_data got %h keep %b exp 00005554 0011", r_data, r_keep); end
    for (int i = 0; i < 14; i++) write_word(8'h60 + 8'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL simul_full got %b exp 1", full); end
    w_data = 8'hEE; wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd12 || wr_err !== 1'b1 || rd_err !== 1'b0) begin errors++; $display("FAIL simul_at_full got cnt %0d wr_err %b rd_err %b exp 12 1 0", count, wr_err, rd_err); end
  endtask

  task automatic test_drain();
    do_flush();
    write_word(8'hA1); write_word(8'hB2);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_off_empty got %b exp 1", empty); end
    read_beat();
    checks++; if (rd_err !== 1'b1 || count !== 5'd2) begin errors++; $display("FAIL drain_off_rd_err got err %b cnt %0d exp 1 2", rd_err, count); end
    drain = 1'b1;
    #1;
    checks++; if (empty !== 1'b0 || r_data !== 32'h0000b2a1 || r_keep !== 4'b0011) begin errors++; $display("FAIL drain_data got empty %b data %h keep %b exp 0 0000b2a1 0011", empty, r_data, r_keep); end
    read_beat();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_err !== 1'b0) begin errors++; $display("FAIL drain_read got cnt %0d empty %b err %b exp 0 1 0", count, empty, rd_err); end
    drain = 1'b0;
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 9; i++) write_word(8'h70 + 8'(i));
    checks++; if (count !== 5'd9) begin errors++; $display("FAIL flush_pre got %0d exp 9", count); end
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; w_data = 8'h99;
    step();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || {wr_err, rd_err} !== 2'b00) begin errors++; $display("FAIL flush_prio got cnt %0d empty %b err %b exp 0 1 00", count, empty, {wr_err, rd_err}); end
    wr_en = 1'b0;
    step();
    checks++; if (rd_err !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL flush_rd_err_supp got err %b cnt %0d exp 0 0", rd_err, count); end
    flush = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 9; i++) write_word(8'h90 + 8'(i));
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd0 || {full, almost_full, empty, almost_empty} !== 4'b0011) begin errors++; $display("FAIL rst_flags got cnt %0d flags %b exp 0 0011", count, {full, almost_full, empty, almost_empty}); end
    checks++; if ({r_keep, r_data} !== 36'd0 || {wr_err, rd_err} !== 2'b00) begin errors++; $display("FAIL rst_outputs got keep %h data %h err %b exp 0 0 00", r_keep, r_data, {wr_err, rd_err}); end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_full();
    test_wrap();
    test_back_to_back();
    test_drain();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
